// File: rtl/verilog_ethernet_pack.sv
// Shared Ethernet types and constants: octet type, CRC-32 constants, MII nibble codes, RX FSM states.
`default_nettype none

package verilog_ethernet_pack;

  typedef logic [7:0] octet_t;

  localparam logic [31:0] ETH_CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [3:0]  ETH_PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIBBLE      = 4'hD;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_PREAMBLE = 2'd1,
    RX_BODY     = 2'd2,
    RX_DROP     = 2'd3
  } mii_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/eth_crc32_d8.sv
// Combinational reflected CRC-32 update over one byte, LSB first (shared with the TX path).
`default_nettype none

module eth_crc32_d8
  import verilog_ethernet_pack::*;
(
  input  logic [31:0] crc_i,
  input  octet_t      data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i]) crc_o = (crc_o >> 1) ^ ETH_CRC32_POLY;
      else                      crc_o = crc_o >> 1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mii_rx_mac.sv
// MII receive MAC front end: preamble/SFD strip, nibble-to-byte assembly, FCS check and strip.
// Optional frame statistics counters are enabled by defining MII_RX_MAC_STATS_EN.
`default_nettype none

module mii_rx_mac
  import verilog_ethernet_pack::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [3:0]  i_rx_d,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  output octet_t      o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_user,
  output logic        o_frame_good,
  output logic        o_frame_bad
`ifdef MII_RX_MAC_STATS_EN
  ,
  output logic [31:0] o_good_count,
  output logic [31:0] o_bad_count,
  output logic [31:0] o_drop_count
`endif
);

  localparam logic [15:0] c_min_len = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] c_max_len = 16'(MAX_FRAME_BYTES);

  mii_rx_state_t state_q, state_d;
  logic          nib_hi_q, nib_hi_d;
  logic [3:0]    low_nib_q, low_nib_d;
  octet_t        line_q [5];
  octet_t        line_d [5];
  logic [2:0]    line_cnt_q, line_cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          er_q, er_d;
  octet_t        data_q, data_d;
  logic          valid_q, valid_d, last_q, last_d, user_q, user_d;
  logic          good_q, good_d, bad_q, bad_d;
  logic          pend_q, pend_d, pend_user_q, pend_user_d;
  octet_t        pend_data_q, pend_data_d;

  octet_t        byte_w;
  logic [31:0]   crc_next;
  logic          frame_err;

  assign byte_w    = {i_rx_d, low_nib_q};
  assign frame_err = (crc_q != ETH_CRC32_RESIDUE) | er_q | nib_hi_q | (cnt_q < c_min_len);

  eth_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_w),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    nib_hi_d    = nib_hi_q;
    low_nib_d   = low_nib_q;
    line_d      = line_q;
    line_cnt_d  = line_cnt_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    er_d        = er_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    user_d      = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    pend_user_d = pend_user_q;

    // End-of-frame beat deferred one cycle so it never abuts the final completion beat.
    if (pend_q) begin
      valid_d = 1'b1;
      data_d  = pend_data_q;
      last_d  = 1'b1;
      user_d  = pend_user_q;
      good_d  = ~pend_user_q;
      bad_d   = pend_user_q;
    end

    case (state_q)
      RX_IDLE: begin
        if (i_rx_dv) state_d = (i_rx_d == ETH_PREAMBLE_NIBBLE) ? RX_PREAMBLE : RX_DROP;
      end
      RX_PREAMBLE: begin
        if (!i_rx_dv)                          state_d = RX_IDLE;
        else if (i_rx_er)                      state_d = RX_DROP;
        else if (i_rx_d == ETH_SFD_NIBBLE) begin
          state_d    = RX_BODY;
          crc_d      = '1;
          cnt_d      = '0;
          line_cnt_d = '0;
          er_d       = 1'b0;
          nib_hi_d   = 1'b0;
        end
        else if (i_rx_d != ETH_PREAMBLE_NIBBLE) state_d = RX_DROP;
      end
      RX_BODY: begin
        if (!i_rx_dv) begin
          state_d = RX_IDLE;
          if (line_cnt_q == 3'd5) begin
            if (valid_q) begin
              pend_d      = 1'b1;
              pend_data_d = line_q[4];
              pend_user_d = frame_err;
            end else begin
              valid_d = 1'b1;
              data_d  = line_q[4];
              last_d  = 1'b1;
              user_d  = frame_err;
              good_d  = ~frame_err;
              bad_d   = frame_err;
            end
          end else begin
            bad_d = 1'b1;
          end
        end else begin
          if (i_rx_er) er_d = 1'b1;
          if (!nib_hi_q) begin
            low_nib_d = i_rx_d;
            nib_hi_d  = 1'b1;
          end else begin
            nib_hi_d  = 1'b0;
            crc_d     = crc_next;
            cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            line_d[0] = byte_w;
            for (int i = 1; i < 5; i++) line_d[i] = line_q[i-1];
            if (line_cnt_q == 3'd5) begin
              valid_d = 1'b1;
              data_d  = line_q[4];
            end else begin
              line_cnt_d = line_cnt_q + 3'd1;
            end
            if (cnt_q == c_max_len) begin
              last_d  = 1'b1;
              user_d  = 1'b1;
              bad_d   = 1'b1;
              state_d = RX_DROP;
            end
          end
        end
      end
      RX_DROP: begin
        if (!i_rx_dv) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= RX_IDLE;
      nib_hi_q    <= 1'b0;
      low_nib_q   <= '0;
      for (int i = 0; i < 5; i++) line_q[i] <= '0;
      line_cnt_q  <= '0;
      crc_q       <= '1;
      cnt_q       <= '0;
      er_q        <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_user_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_hi_q    <= nib_hi_d;
      low_nib_q   <= low_nib_d;
      line_q      <= line_d;
      line_cnt_q  <= line_cnt_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      er_q        <= er_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      user_q      <= user_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_user_q <= pend_user_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_user       = user_q;
  assign o_frame_good = good_q;
  assign o_frame_bad  = bad_q;

`ifdef MII_RX_MAC_STATS_EN
  logic        drop_evt;
  logic [31:0] good_cnt_q, bad_cnt_q, drop_cnt_q;

  assign drop_evt = ((state_q == RX_IDLE) || (state_q == RX_PREAMBLE)) && (state_d == RX_DROP);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (good_q)   good_cnt_q <= good_cnt_q + 32'd1;
      if (bad_q)    bad_cnt_q  <= bad_cnt_q + 32'd1;
      if (drop_evt) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign o_good_count = good_cnt_q;
  assign o_bad_count  = bad_cnt_q;
  assign o_drop_count = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mii_rx_mac.sv
// Bench for mii_rx_mac: scenario tasks with random frames checked against a frame-level reference model.
`default_nettype none

module tb_mii_rx_mac;

  localparam int MIN = 64;
  localparam int MAX = 1518;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rx_d = 4'h0;
  logic       rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_user, o_frame_good, o_frame_bad;
`ifdef MII_RX_MAC_STATS_EN
  logic [31:0] good_count, bad_count, drop_count;
`endif

  mii_rx_mac #(.MIN_FRAME_BYTES(MIN), .MAX_FRAME_BYTES(MAX)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_rx_d       (rx_d),
    .i_rx_dv      (rx_dv),
    .i_rx_er      (rx_er),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .o_user       (o_user),
    .o_frame_good (o_frame_good),
    .o_frame_bad  (o_frame_bad)
`ifdef MII_RX_MAC_STATS_EN
    ,
    .o_good_count (good_count),
    .o_bad_count  (bad_count),
    .o_drop_count (drop_count)
`endif
  );

  always #20 clk = ~clk;

  int    total = 0, bad = 0;
  beat_t got[$];
  beat_t exp_q[$];
  int    n_good = 0, n_bad = 0, viol = 0;
  int    exp_good, exp_bad;
  logic  prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (o_valid) got.push_back({o_data, o_last, o_user});
      if (!o_valid && (o_last || o_user)) viol++;
      if (o_valid && prev_v) viol++;
      if (o_frame_good) n_good++;
      if (o_frame_bad) n_bad++;
      prev_v = o_valid;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc32(input bq_t q, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t q = p;
    logic [31:0] c = crc32(p, p.size());
    q.push_back(c[7:0]); q.push_back(c[15:8]); q.push_back(c[23:16]); q.push_back(c[31:24]);
    return q;
  endfunction

  function automatic bq_t arp();
    bq_t q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
               8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
               8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h00, 8'h01,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h02};
    while (q.size() < 60) q.push_back(8'h00);
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Expected stream derived from frame-level rules: FCS stripped, error flag on the final byte.
  task automatic model(input bq_t body, input bit er, input bit drib);
    int n = body.size();
    bit e;
    exp_q.delete();
    if (n > MAX) begin
      for (int i = 0; i <= MAX - 5; i++) exp_q.push_back({body[i], i == MAX - 5, i == MAX - 5});
      exp_good = 0; exp_bad = 1;
    end else if (n < 5) begin
      exp_good = 0; exp_bad = 1;
    end else begin
      e = (crc32(body, n - 4) != {body[n-1], body[n-2], body[n-3], body[n-4]}) || er || drib || (n < MIN);
      for (int i = 0; i <= n - 5; i++) exp_q.push_back({body[i], i == n - 5, (i == n - 5) && e});
      exp_good = e ? 0 : 1; exp_bad = e ? 1 : 0;
    end
  endtask

  function automatic int diff_beats();
    int m = 0;
    if (got.size() != exp_q.size()) return -1;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk); #1;
    rx_dv = dv; rx_d = d; rx_er = er;
  endtask

  task automatic clear();
    got.delete(); n_good = 0; n_bad = 0; viol = 0;
  endtask

  task automatic send(input bq_t body, input int er_nib, input bit drib, input int rst_nib, input int gap);
    for (int i = 0; i < 16; i++) drive(1'b1, (i == 15) ? 4'hD : 4'h5, 1'b0);
    for (int i = 0; i < 2 * body.size(); i++) begin
      logic [7:0] b = body[i/2];
      @(posedge clk); #1;
      rst_n = (i != rst_nib);
      rx_dv = 1'b1; rx_d = i[0] ? b[7:4] : b[3:0]; rx_er = (i == er_nib);
    end
    if (drib) drive(1'b1, 4'($urandom), 1'b0);
    for (int i = 0; i < gap; i++) begin
      drive(1'b0, 4'h0, 1'b0);
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'h5, 1'b0);
    @(negedge clk);
    total++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_user !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got=%b%b%b required=000", o_valid, o_last, o_user); end
    total++; if (o_frame_good !== 1'b0 || o_frame_bad !== 1'b0 || o_data !== 8'h00) begin
      bad++; $display("FAIL reset_pulses got=%b%b data=%h required=00 data=00", o_frame_good, o_frame_bad, o_data); end
`ifdef MII_RX_MAC_STATS_EN
    total++; if (good_count !== 0 || bad_count !== 0 || drop_count !== 0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d/%0d required=0/0/0", good_count, bad_count, drop_count); end
`endif
    drive(1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_preamble_abort();
    bq_t a = with_fcs(arp());
    clear();
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 2 * a.size(); i++) drive(1'b1, i[0] ? a[i/2][7:4] : a[i/2][3:0], 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'h0, 1'b0);
    total++; if (got.size() !== 0 || n_good + n_bad !== 0) begin
      bad++; $display("FAIL preamble_abort beats=%0d pulses=%0d required=0/0", got.size(), n_good + n_bad); end
`ifdef MII_RX_MAC_STATS_EN
    total++; if (drop_count !== 1) begin
      bad++; $display("FAIL drop_count got=%0d required=1", drop_count); end
`endif
    clear();
    send(a, -1, 1'b0, -1, 8); model(a, 1'b0, 1'b0);
    total++; if (diff_beats() != 0 || n_good !== 1) begin
      bad++; $display("FAIL after_abort diff=%0d good=%0d required=0/1", diff_beats(), n_good); end
  endtask

  task automatic test_arp();
    bq_t a = with_fcs(arp());
    clear();
    send(a, -1, 1'b0, -1, 8); model(a, 1'b0, 1'b0);
    total++; if (diff_beats() != 0) begin
      bad++; $display("FAIL arp_beats diff=%0d got=%0d required=0 beats=%0d", diff_beats(), got.size(), exp_q.size()); end
    total++; if (got.size() != 60 || got[0] !== {8'hFF, 1'b0, 1'b0} || got[got.size()-1] !== {8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL arp_ends n=%0d required=60 first FF last 00/l=1/u=0", got.size()); end
    total++; if (n_good !== 1 || n_bad !== 0 || viol !== 0) begin
      bad++; $display("FAIL arp_pulses good=%0d bad=%0d viol=%0d required=1/0/0", n_good, n_bad, viol); end
`ifdef MII_RX_MAC_STATS_EN
    total++; if (good_count !== 2) begin
      bad++; $display("FAIL good_count got=%0d required=2", good_count); end
`endif
  endtask

  task automatic test_bad_fcs();
    bq_t a = with_fcs(arp());
    a[63] = a[63] ^ 8'h01;
    clear();
    send(a, -1, 1'b0, -1, 8); model(a, 1'b0, 1'b0);
    total++; if (diff_beats() != 0 || !got[got.size()-1].u) begin
      bad++; $display("FAIL bad_fcs_beats diff=%0d required=0 with user=1", diff_beats()); end
    total++; if (n_good !== 0 || n_bad !== 1 || viol !== 0) begin
      bad++; $display("FAIL bad_fcs_pulses good=%0d bad=%0d viol=%0d required=0/1/0", n_good, n_bad, viol); end
  endtask

  task automatic test_rx_er();
    bq_t a = with_fcs(arp());
    clear();
    send(a, 40, 1'b0, -1, 8); model(a, 1'b1, 1'b0);
    total++; if (diff_beats() != 0 || n_bad !== 1 || n_good !== 0) begin
      bad++; $display("FAIL rx_er diff=%0d good=%0d bad=%0d required=0/0/1", diff_beats(), n_good, n_bad); end
  endtask

  task automatic test_dribble();
    bq_t u = '{8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'h00, 8'h0B, 8'h36, 8'h04, 8'h05, 8'h06,
               8'h08, 8'h00, 8'h45, 8'h00};
    u = {u, rand_bytes($urandom_range(60, 120))};
    u = with_fcs(u);
    clear();
    send(u, -1, 1'b1, -1, 8); model(u, 1'b0, 1'b1);
    total++; if (diff_beats() != 0 || n_bad !== 1 || n_good !== 0 || viol !== 0) begin
      bad++; $display("FAIL dribble diff=%0d good=%0d bad=%0d viol=%0d required=0/0/1/0", diff_beats(), n_good, n_bad, viol); end
  endtask

  task automatic test_reset_mid();
    bq_t a = with_fcs(arp());
    int  last_seen = 0;
    clear();
    send(a, -1, 1'b0, 60, 8);
    foreach (got[i]) if (got[i].l) last_seen++;
    total++; if (got.size() > 25 || last_seen !== 0 || n_good + n_bad !== 0) begin
      bad++; $display("FAIL reset_mid beats=%0d lasts=%0d pulses=%0d required<=25/0/0", got.size(), last_seen, n_good + n_bad); end
    clear();
    send(a, -1, 1'b0, -1, 8); model(a, 1'b0, 1'b0);
    total++; if (diff_beats() != 0 || n_good !== 1 || n_bad !== 0) begin
      bad++; $display("FAIL after_reset diff=%0d good=%0d bad=%0d required=0/1/0", diff_beats(), n_good, n_bad); end
  endtask

  task automatic test_lengths();
    int lens[7] = '{4, 5, 20, 63, 64, 1518, 1519};
    foreach (lens[k]) begin
      bq_t f = with_fcs(rand_bytes(lens[k] - 4));
      clear();
      send(f, -1, 1'b0, -1, 8); model(f, 1'b0, 1'b0);
      total++; if (diff_beats() != 0 || n_good !== exp_good || n_bad !== exp_bad || viol !== 0) begin
        bad++; $display("FAIL len_%0d diff=%0d good=%0d bad=%0d viol=%0d required=0/%0d/%0d/0",
                        lens[k], diff_beats(), n_good, n_bad, viol, exp_good, exp_bad); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      bq_t f = with_fcs(rand_bytes($urandom_range(1, 300)));
      int  kind = $urandom_range(0, 3);
      int  er_nib = -1;
      if (kind == 1) f[$urandom_range(0, f.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      if (kind == 2) er_nib = $urandom_range(0, 2 * f.size() - 1);
      clear();
      send(f, er_nib, kind == 3, -1, 8); model(f, kind == 2, kind == 3);
      total++; if (diff_beats() != 0 || n_good !== exp_good || n_bad !== exp_bad || viol !== 0) begin
        bad++; $display("FAIL random_%0d n=%0d kind=%0d diff=%0d good=%0d bad=%0d viol=%0d required=0/%0d/%0d/0",
                        k, f.size(), kind, diff_beats(), n_good, n_bad, viol, exp_good, exp_bad); end
    end
  endtask

  task automatic test_back_to_back();
    bq_t   f1 = with_fcs(rand_bytes($urandom_range(60, 100)));
    bq_t   f2 = with_fcs(rand_bytes($urandom_range(60, 100)));
    beat_t first[$];
    int    g, b;
    clear();
    send(f1, -1, 1'b0, -1, 1);
    send(f2, -1, 1'b0, -1, 8);
    model(f1, 1'b0, 1'b0); first = exp_q; g = exp_good; b = exp_bad;
    model(f2, 1'b0, 1'b0); exp_q = {first, exp_q};
    total++; if (diff_beats() != 0 || n_good !== g + exp_good || n_bad !== b + exp_bad || viol !== 0) begin
      bad++; $display("FAIL back_to_back diff=%0d good=%0d bad=%0d viol=%0d required=0/%0d/%0d/0",
                      diff_beats(), n_good, n_bad, viol, g + exp_good, b + exp_bad); end
  endtask

  initial begin
    test_reset();
    test_preamble_abort();
    test_arp();
    test_bad_fcs();
    test_rx_er();
    test_dribble();
    test_reset_mid();
    test_lengths();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
